// File: rtl/sum_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// No logic; state encoding, mode constants and counter sizing only.
package sum_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sum_serial_nb_if.sv
// Operand/result bundle between operand logic and the serial adder.
// Start is a level sampled only while the adder is idle; no backpressure beyond busy.
interface sum_serial_nb_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ci_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] s_o;
  logic             co_o;
  logic             ov_o;

  modport master (
    output start_i, sub_i, a_i, b_i, ci_i,
    input  busy_o, done_o, s_o, co_o, ov_o
  );

  modport slave (
    input  start_i, sub_i, a_i, b_i, ci_i,
    output busy_o, done_o, s_o, co_o, ov_o
  );
endinterface

// File: rtl/sum1b.sv
// One-bit full adder cell, purely combinational.
// Latency 0; no flow control.
module sum1b (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// File: rtl/sum_serial_nb.sv
// Bit-serial add/subtract using one full-adder cell, LSB first.
// Latency: done pulses the cycle after accept+WIDTH; start is ignored while busy.
module sum_serial_nb
  import sum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  sum_serial_nb_if.slave  bus
);
  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_b_q, sum_q, s_q;
  logic [WIDTH-1:0] sum_nxt;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, mode_q, co_q, ov_q, done_q;
  logic             fa_s, fa_co;
  logic             accept, last_bit;

  sum1b u_fa (
    .a_i  (op_a_q[0]),
    .b_i  (op_b_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    sum_nxt  = {fa_s, sum_q[WIDTH-1:1]};
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        last_bit = (cnt_q == LAST);
        if (last_bit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= MODE_ADD;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // Subtraction is a + ~b + ~borrow_in; the borrow is recovered from carry-out.
        op_a_q  <= bus.a_i;
        op_b_q  <= (bus.sub_i == MODE_SUB) ? ~bus.b_i : bus.b_i;
        carry_q <= (bus.sub_i == MODE_SUB) ? ~bus.ci_i : bus.ci_i;
        mode_q  <= bus.sub_i;
        sum_q   <= '0;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        op_a_q  <= op_a_q >> 1;
        op_b_q  <= op_b_q >> 1;
        carry_q <= fa_co;
        sum_q   <= sum_nxt;
        if (last_bit) begin
          // carry_q here is the carry into the MSB, so overflow is cin_msb ^ cout.
          s_q    <= sum_nxt;
          co_q   <= (mode_q == MODE_SUB) ? ~fa_co : fa_co;
          ov_q   <= carry_q ^ fa_co;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign bus.busy_o = (state_q == RUN);
  assign bus.done_o = done_q;
  assign bus.s_o    = s_q;
  assign bus.co_o   = co_q;
  assign bus.ov_o   = ov_q;

endmodule

// File: tb/tb_sum_serial_nb.sv
// Directed and model-checked bench for the bit-serial adder at WIDTH=8.
module tb_sum_serial_nb;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sum_serial_nb_if #(.WIDTH(W)) bus ();

  sum_serial_nb #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Drives one operation from the current negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic ci, input int inject_k,
                        output int lat, output int busy_cnt, output logic stable);
    logic [7:0] hold;
    lat = 0; busy_cnt = 0; stable = 1'b1; hold = '0;
    bus.start_i = 1'b1; bus.a_i = a; bus.b_i = b; bus.sub_i = sub; bus.ci_i = ci;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start_i = 1'b0; bus.a_i = 8'hA5; bus.b_i = 8'h5A;
        bus.sub_i = ~sub; bus.ci_i = ~ci; hold = bus.s_o;
      end
      if (bus.done_o) begin
        lat = k;
        break;
      end
      if (bus.busy_o) busy_cnt++;
      if (bus.s_o !== hold) stable = 1'b0;
      if (inject_k != 0 && k == inject_k) begin
        bus.start_i = 1'b1; bus.a_i = 8'h11;
      end
      if (inject_k != 0 && k == inject_k + 1) bus.start_i = 1'b0;
    end
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%b done=%b required 0 0", bus.busy_o, bus.done_o);
    end
    checks++;
    if (bus.s_o !== 8'h00 || bus.co_o !== 1'b0 || bus.ov_o !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: s=%h co=%b ov=%b required 00 0 0", bus.s_o, bus.co_o, bus.ov_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat, bc; logic st;
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, lat, bc, st);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL add_ff_01_latency: got %0d required 9", lat); end
    checks++;
    if (bc !== 8) begin errors++; $display("FAIL add_ff_01_busy_cycles: got %0d required 8", bc); end
    checks++;
    if ({bus.s_o, bus.co_o, bus.ov_o} !== {8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_ff_01: s=%h co=%b ov=%b required 00 1 0", bus.s_o, bus.co_o, bus.ov_o);
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b0) begin errors++; $display("FAIL done_pulse_width: done=%b required 0", bus.done_o); end
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, lat, bc, st);
    checks++;
    if ({bus.s_o, bus.co_o, bus.ov_o} !== {8'h80, 1'b0, 1'b1} || lat !== 9) begin
      errors++; $display("FAIL add_7f_01: s=%h co=%b ov=%b lat=%0d required 80 0 1 9", bus.s_o, bus.co_o, bus.ov_o, lat);
    end
    checks++;
    if (st !== 1'b1) begin errors++; $display("FAIL add_7f_01_hold: s_o moved during run, required stable"); end
    @(negedge clk);
    run_op(8'hFF, 8'h00, 1'b0, 1'b1, 0, lat, bc, st);
    checks++;
    if ({bus.s_o, bus.co_o, bus.ov_o} !== {8'h00, 1'b1, 1'b0} || lat !== 9) begin
      errors++; $display("FAIL add_ff_00_ci: s=%h co=%b ov=%b lat=%0d required 00 1 0 9", bus.s_o, bus.co_o, bus.ov_o, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_sub();
    int lat, bc; logic st;
    run_op(8'h05, 8'h07, 1'b1, 1'b0, 0, lat, bc, st);
    checks++;
    if ({bus.s_o, bus.co_o, bus.ov_o} !== {8'hFE, 1'b1, 1'b0} || lat !== 9) begin
      errors++; $display("FAIL sub_05_07: s=%h co=%b ov=%b lat=%0d required fe 1 0 9", bus.s_o, bus.co_o, bus.ov_o, lat);
    end
    @(negedge clk);
    run_op(8'h80, 8'h01, 1'b1, 1'b0, 0, lat, bc, st);
    checks++;
    if ({bus.s_o, bus.co_o, bus.ov_o} !== {8'h7F, 1'b0, 1'b1} || lat !== 9) begin
      errors++; $display("FAIL sub_80_01: s=%h co=%b ov=%b lat=%0d required 7f 0 1 9", bus.s_o, bus.co_o, bus.ov_o, lat);
    end
    @(negedge clk);
    run_op(8'h10, 8'h05, 1'b1, 1'b1, 0, lat, bc, st);
    checks++;
    if ({bus.s_o, bus.co_o, bus.ov_o} !== {8'h0A, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_10_05_bin: s=%h co=%b ov=%b required 0a 0 0", bus.s_o, bus.co_o, bus.ov_o);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int lat, bc; logic st;
    run_op(8'h22, 8'h33, 1'b0, 1'b0, 3, lat, bc, st);
    checks++;
    if ({bus.s_o, bus.co_o, bus.ov_o} !== {8'h55, 1'b0, 1'b0} || lat !== 9) begin
      errors++; $display("FAIL ignore_start: s=%h co=%b ov=%b lat=%0d required 55 0 0 9", bus.s_o, bus.co_o, bus.ov_o, lat);
    end
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL ignore_start_queued: busy=%b required 0", bus.busy_o); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic st;
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 0, lat, bc, st);
    run_op(8'h40, 8'h40, 1'b0, 1'b0, 0, lat, bc, st);
    checks++;
    if (lat !== 9 || bc !== 8) begin
      errors++; $display("FAIL back_to_back_timing: lat=%0d busy=%0d required 9 8", lat, bc);
    end
    checks++;
    if ({bus.s_o, bus.co_o, bus.ov_o} !== {8'h80, 1'b0, 1'b1}) begin
      errors++; $display("FAIL back_to_back_result: s=%h co=%b ov=%b required 80 0 1", bus.s_o, bus.co_o, bus.ov_o);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int dones;
    dones = 0;
    bus.start_i = 1'b1; bus.a_i = 8'h7F; bus.b_i = 8'h01; bus.sub_i = 1'b0; bus.ci_i = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset_flags: busy=%b done=%b required 0 0", bus.busy_o, bus.done_o);
    end
    checks++;
    if (bus.s_o !== 8'h00 || bus.co_o !== 1'b0 || bus.ov_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: s=%h co=%b ov=%b required 00 0 0", bus.s_o, bus.co_o, bus.ov_o);
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL mid_reset_no_done: %0d pulses required 0", dones); end
  endtask

  task automatic test_random();
    int lat, bc, sa, sb, r, ra;
    logic st, sub, ci, exp_co, exp_ov;
    logic [7:0] a, b, exp_s;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom); b = 8'($urandom);
      sub = 1'($urandom); ci = 1'($urandom);
      sa = int'($signed(a)); sb = int'($signed(b));
      if (sub) begin
        ra = int'(a) - int'(b) - int'(ci);
        r  = sa - sb - int'(ci);
        exp_co = (ra < 0);
      end else begin
        ra = int'(a) + int'(b) + int'(ci);
        r  = sa + sb + int'(ci);
        exp_co = (ra > 255);
      end
      exp_s  = 8'(ra);
      exp_ov = (r > 127) || (r < -128);
      run_op(a, b, sub, ci, 0, lat, bc, st);
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL rand_latency #%0d: got %0d required 9", n, lat); end
      checks++;
      if (bus.s_o !== exp_s || bus.co_o !== exp_co || bus.ov_o !== exp_ov) begin
        errors++;
        $display("FAIL rand_result #%0d a=%h b=%h sub=%b ci=%b: s=%h co=%b ov=%b required %h %b %b",
                 n, a, b, sub, ci, bus.s_o, bus.co_o, bus.ov_o, exp_s, exp_co, exp_ov);
      end
      checks++;
      if (st !== 1'b1) begin errors++; $display("FAIL rand_hold #%0d: s_o moved during run, required stable", n); end
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
  endtask

  initial begin
    bus.start_i = 1'b0; bus.sub_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.ci_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
